// File: rtl/decode_pkg.sv
// Opcode and funct3 encodings shared by decode and alu, plus decode helper types.
package decode_pkg;

  typedef enum logic [6:0] {
    OPC_OP        = 7'b0110011,
    OPC_OP_IMM    = 7'b0010011,
    OPC_OP_32     = 7'b0111011,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_LUI       = 7'b0110111,
    OPC_AUIPC     = 7'b0010111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_REG,
    CLS_IMM,
    CLS_LUI,
    CLS_AUIPC
  } iclass_e;

  typedef struct packed {
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [4:0] rd;
  } regfields_t;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // 32-bit word ops only implement add/sub, sll, srl/sra.
  function automatic logic w_funct3_ok(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

  // funct7 = 0100000 only selects sub (000) or sra (101).
  function automatic logic funct7_ok(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
  endfunction

endpackage

// File: rtl/decode_imm.sv
// Combinational instruction classification, legality check and operand-2 immediate.
module decode_imm
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_val_o,
  output iclass_e         cls_o,
  output logic            is_w_o,
  output logic            is_shift_o,
  output logic            illegal_o,
  output regfields_t      fields_o
);

  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            f3_shift;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] u_imm;

  assign f3       = inst_i[14:12];
  assign f7       = inst_i[31:25];
  assign f3_shift = (f3 == F3_SLL) || (f3 == F3_SR);
  assign i_imm    = XLEN'($signed(inst_i[31:20]));
  assign u_imm    = XLEN'($signed({inst_i[31:12], 12'b0}));

  assign fields_o = '{rs2: inst_i[24:20], rs1: inst_i[19:15], rd: inst_i[11:7]};

  always_comb begin
    cls_o      = CLS_ILLEGAL;
    is_w_o     = 1'b0;
    is_shift_o = 1'b0;
    illegal_o  = 1'b0;
    imm_val_o  = '0;
    case (inst_i[6:0])
      OPC_OP: begin
        cls_o     = CLS_REG;
        illegal_o = !funct7_ok(f7, f3);
      end
      OPC_OP_32: begin
        cls_o     = CLS_REG;
        is_w_o    = 1'b1;
        illegal_o = !funct7_ok(f7, f3) || !w_funct3_ok(f3);
      end
      OPC_OP_IMM: begin
        cls_o = CLS_IMM;
        if (f3_shift) begin
          // RV64 shamt is 6 bits, so only inst[31:26] carries the sra select.
          is_shift_o = 1'b1;
          imm_val_o  = XLEN'(inst_i[25:20]);
          illegal_o  = !funct7_ok({inst_i[31:26], 1'b0}, f3);
        end else begin
          imm_val_o = i_imm;
        end
      end
      OPC_OP_IMM_32: begin
        cls_o  = CLS_IMM;
        is_w_o = 1'b1;
        if (f3_shift) begin
          is_shift_o = 1'b1;
          imm_val_o  = XLEN'(inst_i[24:20]);
          illegal_o  = !funct7_ok(f7, f3);
        end else begin
          imm_val_o = i_imm;
        end
        if (!w_funct3_ok(f3)) illegal_o = 1'b1;
      end
      OPC_LUI: begin
        cls_o     = CLS_LUI;
        imm_val_o = u_imm;
      end
      OPC_AUIPC: begin
        cls_o     = CLS_AUIPC;
        imm_val_o = u_imm;
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) cls_o = CLS_ILLEGAL;
  end

endmodule

// File: rtl/decode.sv
// RV64I integer decode stage: one word per cycle, registered bundle one edge after accept.
// Forwards from the immediately preceding valid bundle; bubbles write x0.
module decode
  import decode_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int X2MSB = $clog2(XLEN) - 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  output logic             sub,
  output logic             ashr,
  output logic             w,
  output logic             fwd1,
  output logic             fwd2,
  output logic             imm1,
  output logic             imm2,
  output logic [2:0]       funct3,
  output logic [XLEN-1:0]  imm1val,
  output logic [XLEN-1:0]  imm2val,
  output logic [X2MSB:0]   rs1,
  output logic [X2MSB:0]   rs2,
  output logic [X2MSB:0]   rd,
  output logic             illegal,
  output logic [63:0]      instret
);

  typedef logic [X2MSB:0] idx_t;

  logic            ready_q;
  logic            out_valid_q, out_valid_d;
  logic            sub_q, sub_d;
  logic            ashr_q, ashr_d;
  logic            w_q, w_d;
  logic            fwd1_q, fwd1_d;
  logic            fwd2_q, fwd2_d;
  logic            imm1_q, imm1_d;
  logic            imm2_q, imm2_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] imm1val_q, imm1val_d;
  logic [XLEN-1:0] imm2val_q, imm2val_d;
  idx_t            rs1_q, rs1_d;
  idx_t            rs2_q, rs2_d;
  idx_t            rd_q, rd_d;
  logic            illegal_q, illegal_d;
  logic [63:0]     instret_q, instret_d;

  logic [XLEN-1:0] dec_imm;
  iclass_e         dec_cls;
  logic            dec_w;
  logic            dec_shift;
  logic            dec_illegal;
  regfields_t      dec_fields;
  logic            accept;
  logic [2:0]      f3;
  idx_t            src1;
  idx_t            src2;

  decode_imm #(.XLEN(XLEN)) u_decode_imm (
    .inst_i     (in_inst),
    .imm_val_o  (dec_imm),
    .cls_o      (dec_cls),
    .is_w_o     (dec_w),
    .is_shift_o (dec_shift),
    .illegal_o  (dec_illegal),
    .fields_o   (dec_fields)
  );

  assign in_ready = ready_q && reset_n;
  assign accept   = in_valid && in_ready;
  assign f3       = in_inst[14:12];
  assign src1     = idx_t'(dec_fields.rs1);
  assign src2     = idx_t'(dec_fields.rs2);

  // rd_q is zero for every bubble, so a match alone implies a valid non-x0 producer.
  always_comb begin
    out_valid_d = 1'b0;
    sub_d       = 1'b0;
    ashr_d      = 1'b0;
    w_d         = 1'b0;
    fwd1_d      = 1'b0;
    fwd2_d      = 1'b0;
    imm1_d      = 1'b1;
    imm2_d      = 1'b1;
    funct3_d    = F3_ADD;
    imm1val_d   = '0;
    imm2val_d   = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    rd_d        = '0;
    illegal_d   = illegal_q;
    instret_d   = instret_q;
    if (accept) begin
      if (dec_illegal) begin
        illegal_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        rd_d        = idx_t'(dec_fields.rd);
        instret_d   = instret_q + 64'd1;
        case (dec_cls)
          CLS_REG, CLS_IMM: begin
            funct3_d = f3;
            w_d      = dec_w;
            ashr_d   = (f3 == F3_SR) && in_inst[30];
            sub_d    = (dec_cls == CLS_REG) && (f3 == F3_ADD) && in_inst[30];
            if (src1 != '0) begin
              imm1_d = 1'b0;
              rs1_d  = src1;
              fwd1_d = out_valid_q && (rd_q == src1);
            end
            if (dec_cls == CLS_IMM) begin
              imm2val_d = dec_imm;
            end else if (src2 != '0) begin
              imm2_d = 1'b0;
              rs2_d  = src2;
              fwd2_d = out_valid_q && (rd_q == src2);
            end
          end
          CLS_LUI: begin
            imm2val_d = dec_imm;
          end
          CLS_AUIPC: begin
            imm1val_d = in_pc;
            imm2val_d = dec_imm;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sub_q       <= 1'b0;
      ashr_q      <= 1'b0;
      w_q         <= 1'b0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      imm1_q      <= 1'b1;
      imm2_q      <= 1'b1;
      funct3_q    <= F3_ADD;
      imm1val_q   <= '0;
      imm2val_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
      instret_q   <= '0;
    end else begin
      ready_q     <= 1'b1;
      out_valid_q <= out_valid_d;
      sub_q       <= sub_d;
      ashr_q      <= ashr_d;
      w_q         <= w_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      imm1_q      <= imm1_d;
      imm2_q      <= imm2_d;
      funct3_q    <= funct3_d;
      imm1val_q   <= imm1val_d;
      imm2val_q   <= imm2val_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      illegal_q   <= illegal_d;
      instret_q   <= instret_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sub       = sub_q;
  assign ashr      = ashr_q;
  assign w         = w_q;
  assign fwd1      = fwd1_q;
  assign fwd2      = fwd2_q;
  assign imm1      = imm1_q;
  assign imm2      = imm2_q;
  assign funct3    = funct3_q;
  assign imm1val   = imm1val_q;
  assign imm2val   = imm2val_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign illegal   = illegal_q;
  assign instret   = instret_q;

  logic unused_ok;
  assign unused_ok = dec_shift;

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage.
module tb_decode;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP32   = 7'b0111011;
  localparam logic [6:0] OPIMMW = 7'b0011011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  logic        clock, reset_n, in_valid, in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid, sub, ashr, w, fwd1, fwd2, imm1, imm2, illegal;
  logic [2:0]  funct3;
  logic [63:0] imm1val, imm2val, instret;
  logic [5:0]  rs1, rs2, rd;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_instret = 64'd0;

  decode #(.XLEN(64)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .sub(sub), .ashr(ashr),
    .w(w), .fwd1(fwd1), .fwd2(fwd2), .imm1(imm1), .imm2(imm2), .funct3(funct3),
    .imm1val(imm1val), .imm2val(imm2val), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal(illegal), .instret(instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
      input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] d,
      input logic [6:0] op);
    return {imm, d, op};
  endfunction

  // Present one word for one edge, then settle past the edge before checks.
  task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(1'b1, enc_i(12'd7, 5'd0, 3'b000, 5'd5, OPIMM), 64'h0);
    step(1'b1, enc_i(12'd7, 5'd0, 3'b000, 5'd5, OPIMM), 64'h0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0h exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
    checks++; if ({imm1, imm2} !== 2'b11) begin failures++; $display("FAIL rst_imm got=%0h exp=3", {imm1, imm2}); end
    checks++; if ({rd, rs1, rs2} !== 18'd0) begin failures++; $display("FAIL rst_idx got=%0h exp=0", {rd, rs1, rs2}); end
    checks++; if ({instret, illegal} !== 65'd0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", {instret, illegal}); end
    reset_n = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_deassert_ready got=%0h exp=0", in_ready); end
    step(1'b1, enc_i(12'd7, 5'd0, 3'b000, 5'd5, OPIMM), 64'h0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_drop got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_up got=%0h exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    step(1'b1, enc_i(12'd7, 5'd0, 3'b000, 5'd5, OPIMM), 64'h0);
    exp_instret++;
    checks++; if ({out_valid, rd} !== {1'b1, 6'd5}) begin failures++; $display("FAIL b2b_addi_vld_rd got=%0h exp=%0h", {out_valid, rd}, {1'b1, 6'd5}); end
    checks++; if ({imm1, imm2, fwd1} !== 3'b110) begin failures++; $display("FAIL b2b_addi_ctl got=%0h exp=6", {imm1, imm2, fwd1}); end
    checks++; if (imm2val !== 64'd7 || imm1val !== 64'd0) begin failures++; $display("FAIL b2b_addi_imm got=%0h/%0h exp=0/7", imm1val, imm2val); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL b2b_instret1 got=%0d exp=%0d", instret, exp_instret); end
    step(1'b1, enc_r(7'd0, 5'd5, 5'd5, 3'b000, 5'd6, OP), 64'h4);
    exp_instret++;
    checks++; if ({fwd1, fwd2} !== 2'b11) begin failures++; $display("FAIL b2b_fwd got=%0h exp=3", {fwd1, fwd2}); end
    checks++; if ({rs1, rs2, rd} !== {6'd5, 6'd5, 6'd6}) begin failures++; $display("FAIL b2b_idx got=%0h exp=%0h", {rs1, rs2, rd}, {6'd5, 6'd5, 6'd6}); end
    checks++; if ({out_valid, imm1, imm2, sub} !== 4'b1000) begin failures++; $display("FAIL b2b_add_ctl got=%0h exp=8", {out_valid, imm1, imm2, sub}); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL b2b_instret2 got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_bubble_break;
    step(1'b1, enc_i(12'd7, 5'd0, 3'b000, 5'd5, OPIMM), 64'h0);
    exp_instret++;
    step(1'b0, enc_r(7'd0, 5'd5, 5'd5, 3'b000, 5'd6, OP), 64'h0);
    checks++; if ({out_valid, rd, imm1, imm2, funct3} !== {1'b0, 6'd0, 1'b1, 1'b1, 3'd0}) begin failures++; $display("FAIL bub_bundle got=%0h exp=%0h", {out_valid, rd, imm1, imm2, funct3}, {1'b0, 6'd0, 1'b1, 1'b1, 3'd0}); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL bub_instret got=%0d exp=%0d", instret, exp_instret); end
    step(1'b1, enc_r(7'd0, 5'd5, 5'd5, 3'b000, 5'd6, OP), 64'h8);
    exp_instret++;
    checks++; if ({out_valid, fwd1, fwd2} !== 3'b100) begin failures++; $display("FAIL bub_nofwd got=%0h exp=4", {out_valid, fwd1, fwd2}); end
  endtask

  task automatic test_sub_x0;
    step(1'b1, enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd1, OP), 64'h0);
    exp_instret++;
    checks++; if ({imm1, imm2, rd} !== {1'b1, 1'b1, 6'd1} || imm2val !== 64'd0) begin failures++; $display("FAIL x0_add got=%0h exp=%0h", {imm1, imm2, rd}, {1'b1, 1'b1, 6'd1}); end
    step(1'b1, enc_r(7'b0100000, 5'd0, 5'd1, 3'b000, 5'd2, OP), 64'h4);
    exp_instret++;
    checks++; if ({fwd1, fwd2, imm1, imm2, sub} !== 5'b10011) begin failures++; $display("FAIL sub_ctl got=%0h exp=13", {fwd1, fwd2, imm1, imm2, sub}); end
    checks++; if ({rs1, rd} !== {6'd1, 6'd2} || imm2val !== 64'd0) begin failures++; $display("FAIL sub_idx got=%0h imm2val=%0h", {rs1, rd}, imm2val); end
  endtask

  task automatic test_shift_w;
    step(1'b1, enc_i(12'h41F, 5'd8, 3'b101, 5'd7, OPIMMW), 64'h0);
    exp_instret++;
    checks++; if ({out_valid, ashr, w, imm2, funct3} !== 7'b1111101) begin failures++; $display("FAIL sraiw_ctl got=%0h exp=7d", {out_valid, ashr, w, imm2, funct3}); end
    checks++; if (imm2val !== 64'd31 || {rs1, rd} !== {6'd8, 6'd7}) begin failures++; $display("FAIL sraiw_imm got=%0h idx=%0h", imm2val, {rs1, rd}); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL sraiw_legal got=%0h exp=0", illegal); end
    step(1'b1, enc_i(12'h43F, 5'd4, 3'b101, 5'd3, OPIMM), 64'h4);
    exp_instret++;
    checks++; if ({ashr, w, sub} !== 3'b100 || imm2val !== 64'd63) begin failures++; $display("FAIL srai63 got=%0h imm2val=%0h", {ashr, w, sub}, imm2val); end
    step(1'b1, enc_i(12'h43F, 5'd8, 3'b101, 5'd7, OPIMMW), 64'h8);
    checks++; if ({out_valid, rd, illegal} !== {1'b0, 6'd0, 1'b1}) begin failures++; $display("FAIL sraiw_bad got=%0h exp=%0h", {out_valid, rd, illegal}, {1'b0, 6'd0, 1'b1}); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL sraiw_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_upper;
    step(1'b1, enc_u(20'h80000, 5'd9, AUIPC), 64'h1000);
    exp_instret++;
    checks++; if (imm1val !== 64'h1000 || imm2val !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL auipc_imm got=%0h/%0h", imm1val, imm2val); end
    checks++; if ({out_valid, imm1, imm2, funct3, rd} !== {1'b1, 1'b1, 1'b1, 3'd0, 6'd9}) begin failures++; $display("FAIL auipc_ctl got=%0h exp=%0h", {out_valid, imm1, imm2, funct3, rd}, {1'b1, 1'b1, 1'b1, 3'd0, 6'd9}); end
    step(1'b1, enc_u(20'h12345, 5'd10, LUI), 64'h2000);
    exp_instret++;
    checks++; if (imm1val !== 64'd0 || imm2val !== 64'h1234_5000 || rs1 !== 6'd0) begin failures++; $display("FAIL lui got=%0h/%0h rs1=%0h", imm1val, imm2val, rs1); end
    step(1'b1, enc_i(12'hFFF, 5'd12, 3'b000, 5'd11, OPIMM), 64'h2004);
    exp_instret++;
    checks++; if (imm2val !== 64'hFFFF_FFFF_FFFF_FFFF || {imm1, fwd1, rs1} !== {1'b0, 1'b0, 6'd12}) begin failures++; $display("FAIL addi_neg got=%0h ctl=%0h", imm2val, {imm1, fwd1, rs1}); end
  endtask

  task automatic test_illegal_misc;
    step(1'b1, enc_r(7'd0, 5'd3, 5'd2, 3'b010, 5'd1, OP32), 64'h0);
    checks++; if ({out_valid, rd} !== 7'd0) begin failures++; $display("FAIL op32_f3 got=%0h exp=0", {out_valid, rd}); end
    step(1'b1, 32'h0000_0073, 64'h4);
    checks++; if ({out_valid, rd} !== 7'd0) begin failures++; $display("FAIL bad_opcode got=%0h exp=0", {out_valid, rd}); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL illegal_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_reset_midstream;
    step(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPIMM), 64'h0);
    step(1'b1, enc_i(12'd2, 5'd0, 3'b000, 5'd2, OPIMM), 64'h4);
    step(1'b1, enc_i(12'd3, 5'd0, 3'b000, 5'd3, OPIMM), 64'h8);
    reset_n = 1'b0;
    step(1'b1, enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4, OP), 64'hC);
    exp_instret = 64'd0;
    checks++; if ({out_valid, illegal, instret} !== 66'd0) begin failures++; $display("FAIL mid_rst got=%0h exp=0", {out_valid, illegal, instret}); end
    reset_n = 1'b1;
    step(1'b1, enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4, OP), 64'hC);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_drop got=%0h exp=0", out_valid); end
    step(1'b1, enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4, OP), 64'hC);
    exp_instret++;
    checks++; if ({out_valid, fwd1, fwd2, rd} !== {1'b1, 1'b0, 1'b0, 6'd4}) begin failures++; $display("FAIL mid_word got=%0h exp=%0h", {out_valid, fwd1, fwd2, rd}, {1'b1, 1'b0, 1'b0, 6'd4}); end
    checks++; if (instret !== exp_instret || illegal !== 1'b0) begin failures++; $display("FAIL mid_cnt got=%0d illegal=%0h exp=%0d/0", instret, illegal, exp_instret); end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_inst  = 32'd0;
    in_pc    = 64'd0;
    test_reset;
    test_back_to_back;
    test_bubble_break;
    test_sub_x0;
    test_shift_w;
    test_upper;
    test_illegal_misc;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
